// File: rtl/decryption_cfg_master.sv
// Register-access initiator for the decryption regfile: takes one command at a
// time, pulses a read/write strobe, waits for done (with timeout), returns a response.
//
// state | meaning
// IDLE  | ready for a command, no transaction in flight
// ISSUE | strobe high for this single cycle; done/error from regfile ignored
// WAIT  | strobe low, counting cycles until done or timeout
// RESP  | response presented and held until rsp_ready
module decryption_cfg_master #(
    parameter int addr_witdth    = 8,
    parameter int reg_width      = 16,
    parameter int timeout_cycles = 15
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic                   i_cmd_write,
    input  logic [addr_witdth-1:0] i_cmd_addr,
    input  logic [reg_width-1:0]   i_cmd_wdata,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [reg_width-1:0]   o_rsp_rdata,
    output logic                   o_rsp_error,
    output logic                   o_rsp_timeout,
    output logic                   o_busy,
    output logic [addr_witdth-1:0] o_reg_addr,
    output logic                   o_reg_read,
    output logic                   o_reg_write,
    output logic [reg_width-1:0]   o_reg_wdata,
    input  logic [reg_width-1:0]   i_reg_rdata,
    input  logic                   i_reg_done,
    input  logic                   i_reg_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [7:0] C_CNT_LAST = 8'(timeout_cycles - 1);

    logic [1:0]             r_state;
    logic [7:0]             r_cnt;
    logic                   r_is_write;
    logic [addr_witdth-1:0] r_reg_addr;
    logic [reg_width-1:0]   r_reg_wdata;
    logic                   r_reg_read;
    logic                   r_reg_write;
    logic                   r_rsp_valid;
    logic [reg_width-1:0]   r_rsp_rdata;
    logic                   r_rsp_error;
    logic                   r_rsp_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_is_write    <= 1'b0;
            r_reg_addr    <= '0;
            r_reg_wdata   <= '0;
            r_reg_read    <= 1'b0;
            r_reg_write   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_reg_addr  <= i_cmd_addr;
                        r_reg_wdata <= i_cmd_write ? i_cmd_wdata : '0;
                        r_is_write  <= i_cmd_write;
                        r_reg_write <= i_cmd_write;
                        r_reg_read  <= ~i_cmd_write;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_reg_read  <= 1'b0;
                    r_reg_write <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // done on the limit edge still wins over the timeout
                    if (i_reg_done) begin
                        r_rsp_error   <= i_reg_error;
                        r_rsp_rdata   <= r_is_write ? '0 : i_reg_rdata;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_rsp_error   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // gated by rst_n so nothing is offered while reset is held
    assign o_cmd_ready   = (r_state == S_IDLE) && i_rst_n;
    assign o_busy        = (r_state != S_IDLE);
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_error   = r_rsp_error;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_reg_addr    = r_reg_addr;
    assign o_reg_read    = r_reg_read;
    assign o_reg_write   = r_reg_write;
    assign o_reg_wdata   = r_reg_wdata;

endmodule
